// File: rtl/gray_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : gray_seq_gen
//  Description : Valid/ready source of consecutive N-bit Gray codes (up/down)
//                from a binary seed. Optional one-bit-step checker is enabled
//                by defining GRAY_SEQ_CHECK_EN (adds output chk_err).
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_seq_gen #(
    parameter int N     = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [N-1:0]     seed,
    input  logic [LEN_W-1:0] len,
    output logic [N-1:0]     out_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_wrap,
    output logic             done,
    output logic             busy
`ifdef GRAY_SEQ_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_gray;
    logic             r_valid;
    logic             r_wrap;
    logic             r_done;
    logic             r_busy;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_dir;

    logic             w_accept;
    logic [N-1:0]     w_b_step;
    logic             w_step_wrap;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_last;

    function automatic logic [N-1:0] f_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign w_accept    = (r_state == c_RUN) && r_valid && out_ready;
    assign w_b_step    = r_dir ? (r_b + 1'b1) : (r_b - 1'b1);
    assign w_step_wrap = r_dir ? (&r_b) : (~|r_b);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_last      = (r_len != '0) && (w_cnt_inc == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_b     <= '0;
            r_gray  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= c_IDLE;
                r_valid <= 1'b0;
                r_wrap  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start && en) begin
                            r_b     <= seed;
                            r_gray  <= f_gray(seed);
                            r_valid <= 1'b1;
                            r_wrap  <= 1'b0;
                            r_cnt   <= '0;
                            r_len   <= len;
                            r_dir   <= dir;
                            r_busy  <= 1'b1;
                            r_state <= c_RUN;
                        end
                    end
                    c_RUN: begin
                        if (w_accept) begin
                            r_cnt <= w_cnt_inc;
                            if (w_last) begin
                                r_valid <= 1'b0;
                                r_wrap  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= c_DONE;
                            end else if (en) begin
                                r_b    <= w_b_step;
                                r_gray <= f_gray(w_b_step);
                                r_wrap <= w_step_wrap;
                            end else begin
                                r_valid <= 1'b0;
                                r_wrap  <= 1'b0;
                            end
                        end else if (!r_valid && en) begin
                            // Beat consumed while frozen: resume with the successor.
                            r_b     <= w_b_step;
                            r_gray  <= f_gray(w_b_step);
                            r_wrap  <= w_step_wrap;
                            r_valid <= 1'b1;
                        end
                    end
                    c_DONE: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_gray  = r_gray;
    assign out_valid = r_valid;
    assign out_wrap  = r_wrap;
    assign done      = r_done;
    assign busy      = r_busy;

`ifdef GRAY_SEQ_CHECK_EN
    logic [N-1:0] r_prev;
    logic         r_have_prev;
    logic         r_chk_err;
    logic [N-1:0] w_diff;
    logic         w_one_bit;

    assign w_diff    = r_prev ^ r_gray;
    assign w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - 1'b1)) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_chk_err   <= 1'b0;
        end else begin
            if (abort || (r_state == c_IDLE)) begin
                r_have_prev <= 1'b0;
            end else if (w_accept) begin
                if (r_have_prev && !w_one_bit) begin
                    r_chk_err <= 1'b1;
                end
                r_prev      <= r_gray;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_seq_gen
//  Description : Self-checking bench for gray_seq_gen (N=4, LEN_W=8): vector
//                table, directed corner sequences, randomized scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_seq_gen;

    localparam int N     = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             start;
    logic             abort;
    logic             dir;
    logic [N-1:0]     seed;
    logic [LEN_W-1:0] len;
    logic [N-1:0]     out_gray;
    logic             out_valid;
    logic             out_ready;
    logic             out_wrap;
    logic             done;
    logic             busy;
`ifdef GRAY_SEQ_CHECK_EN
    logic             chk_err;
`endif

    int nvec = 0;
    int nmis = 0;

    gray_seq_gen #(.N(N), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .abort     (abort),
        .dir       (dir),
        .seed      (seed),
        .len       (len),
        .out_gray  (out_gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wrap  (out_wrap),
        .done      (done),
        .busy      (busy)
`ifdef GRAY_SEQ_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit st, ab, en, rd, dr;
        int sd, ln;
        bit ev;
        int eg;
        bit ew, ed, eb;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] g(input int v);
        logic [N-1:0] b;
        b = v[N-1:0];
        return b ^ (b >> 1);
    endfunction

    // k-th binary value of a run, modulo 2^N
    function automatic int bk(input int s, input bit d, input int k);
        int r;
        r = d ? s + k : s - k;
        return r & ((1 << N) - 1);
    endfunction

    function automatic bit wk(input int s, input bit d, input int k);
        if (k == 0) return 1'b0;
        return d ? (bk(s, d, k) == 0) : (bk(s, d, k) == (1 << N) - 1);
    endfunction

    function automatic vec_t mk(bit st, bit ab, bit e, bit rd, bit dr, int sd, int ln,
                                bit ev, int eg, bit ew, bit ed, bit eb);
        vec_t v;
        v.st = st; v.ab = ab; v.en = e; v.rd = rd; v.dr = dr; v.sd = sd; v.ln = ln;
        v.ev = ev; v.eg = eg; v.ew = ew; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        start = v.st; abort = v.ab; en = v.en; out_ready = v.rd; dir = v.dr;
        seed = v.sd[N-1:0]; len = v.ln[LEN_W-1:0];
    endtask

    initial begin
        int  k, m_len, accepts;
        bit  m_run, m_done_now, m_just, m_dir, p_stall, acc;
        int  m_seed;
        logic [N-1:0] p_gray;

        rst = 1'b1; en = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0;
        seed = '0; len = '0; out_ready = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_gray", out_gray, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", out_wrap, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // seed=0 len=4 up
        tbl.push_back(mk(1,0,1,1,1, 0,4, 1,4'b0000,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 0,4, 1,4'b0001,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 0,4, 1,4'b0011,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 0,4, 1,4'b0010,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 0,4, 0,0,0,1,1));
        tbl.push_back(mk(0,0,1,1,1, 0,4, 0,0,0,0,0));
        // seed=0 len=2 down, wrap on second beat
        tbl.push_back(mk(1,0,1,1,0, 0,2, 1,4'b0000,0,0,1));
        tbl.push_back(mk(0,0,1,1,0, 0,2, 1,4'b1000,1,0,1));
        tbl.push_back(mk(0,0,1,1,0, 0,2, 0,0,0,1,1));
        tbl.push_back(mk(0,0,1,1,0, 0,2, 0,0,0,0,0));
        // seed=5 len=3 with stalled first beat
        tbl.push_back(mk(1,0,1,0,1, 5,3, 1,4'b0111,0,0,1));
        tbl.push_back(mk(0,0,1,0,1, 5,3, 1,4'b0111,0,0,1));
        tbl.push_back(mk(0,0,1,0,1, 5,3, 1,4'b0111,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 5,3, 1,4'b0101,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 5,3, 1,4'b0100,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 5,3, 0,0,0,1,1));
        tbl.push_back(mk(0,0,1,1,1, 5,3, 0,0,0,0,0));
        // en=0 freeze: pending beat accepted, then resume with successor, then abort
        tbl.push_back(mk(1,0,1,1,1, 3,0, 1,4'b0010,0,0,1));
        tbl.push_back(mk(0,0,0,1,1, 3,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,1,1, 3,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 3,0, 1,4'b0110,0,0,1));
        tbl.push_back(mk(0,1,1,1,1, 3,0, 0,0,0,0,0));
        // start & abort together, start with en=0
        tbl.push_back(mk(1,1,1,1,1, 7,3, 0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1, 7,3, 0,0,0,0,0));
        // seed=15 up: no wrap on seed beat, wrap on next
        tbl.push_back(mk(1,0,1,1,1, 15,2, 1,4'b1000,0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 15,2, 1,4'b0000,1,0,1));
        tbl.push_back(mk(0,0,1,1,1, 15,2, 0,0,0,1,1));
        tbl.push_back(mk(0,0,1,1,1, 15,2, 0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_gray", i), out_gray, tbl[i].eg);
                chk($sformatf("tbl%0d_wrap", i), out_wrap, tbl[i].ew);
            end
        end

        // free-running from 14 for 20 beats, then abort
        start = 1'b1; abort = 1'b0; en = 1'b1; out_ready = 1'b1; dir = 1'b1; seed = 4'd14; len = '0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk("free_valid", out_valid, 1);
            chk("free_gray", out_gray, g(bk(14, 1'b1, j)));
            chk("free_wrap", out_wrap, wk(14, 1'b1, j));
            chk("free_done", done, 0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);

        // start while busy ignored, async reset mid-run, restart
        start = 1'b1; seed = 4'd9; len = 8'd8; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("r5_b0", out_gray, g(9));
        @(negedge clk);
        chk("r5_b1", out_gray, g(10));
        start = 1'b1; seed = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("r5_busy_start", out_gray, g(11));
        #2 rst = 1'b1;
        #1;
        chk("r5_rst_valid", out_valid, 0);
        chk("r5_rst_busy", busy, 0);
        chk("r5_rst_gray", out_gray, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; seed = 4'd6; len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        chk("r5_restart", out_gray, g(6));
        @(negedge clk);
        chk("r5_second", out_gray, g(7));
        @(negedge clk);
        chk("r5_done", done, 1);
        @(negedge clk);
        chk("r5_idle", busy, 0);

        // randomized runs against a run-level scoreboard
        k = 0; m_len = 0; accepts = 0; m_run = 0; m_done_now = 0; m_just = 0;
        m_dir = 0; m_seed = 0; p_stall = 0; p_gray = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_done", done, m_done_now);
            chk("rnd_busy", busy, m_run || m_done_now);
            if (!m_run) chk("rnd_valid_idle", out_valid, 0);
            if (m_just) chk("rnd_first_valid", out_valid, 1);
            if (p_stall) begin
                chk("rnd_hold_valid", out_valid, 1);
                chk("rnd_hold_gray", out_gray, p_gray);
            end
            if (m_run && out_valid) begin
                chk("rnd_gray", out_gray, g(bk(m_seed, m_dir, k)));
                chk("rnd_wrap", out_wrap, wk(m_seed, m_dir, k));
            end

            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            dir       = 1'($urandom_range(0, 1));
            seed      = N'($urandom_range(0, (1 << N) - 1));
            len       = LEN_W'($urandom_range(0, 6));

            acc     = m_run && out_valid && out_ready;
            p_stall = m_run && out_valid && !out_ready && !abort;
            p_gray  = out_gray;
            m_just  = 1'b0;
            if (abort) begin
                m_run = 1'b0;
                m_done_now = 1'b0;
            end else if (m_done_now) begin
                m_done_now = 1'b0;
            end else if (!m_run) begin
                if (start && en) begin
                    m_run = 1'b1; m_just = 1'b1; k = 0;
                    m_seed = int'(seed); m_dir = dir; m_len = int'(len);
                end
            end else if (acc) begin
                k++;
                accepts++;
                if (m_len != 0 && k == m_len) begin
                    m_run = 1'b0;
                    m_done_now = 1'b1;
                end
            end
        end
        chk("rnd_accepts", (accepts > 200) ? 1 : 0, 1);

`ifdef GRAY_SEQ_CHECK_EN
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("chk_clean_after_rnd", chk_err, 0);
        start = 1'b1; en = 1'b1; out_ready = 1'b1; dir = 1'b1; seed = '0; len = '0;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk("chk_run", chk_err, 0);
        end
        dut.r_b = dut.r_b + 4'd2;
        begin
            int waited;
            waited = 0;
            while (chk_err !== 1'b1 && waited < 8) begin
                @(negedge clk);
                waited++;
            end
        end
        chk("chk_set", chk_err, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("chk_sticky", chk_err, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
